// File: rtl/zapper_pkg.sv
// Shared types for the light-gun sequencer and the renderer that consumes flash_mode.
package zapper_pkg;

  localparam int DEFAULT_N_TARGETS = 4;

  typedef enum logic [1:0] {
    NORMAL = 2'd0,
    BLACK  = 2'd1,
    TARGET = 2'd2
  } flash_mode_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PENDING,
    ST_BLACK,
    ST_SCAN,
    ST_RESULT,
    ST_HELD
  } state_t;

endpackage

// File: rtl/zapper_sequencer_sync2.sv
// Two-flop synchronizer for the raw zapper trigger and photodiode lines.
module sync2 (
  input  logic clk,
  input  logic screen_reset,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or posedge screen_reset) begin
    if (screen_reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/zapper_sequencer.sv
// Zapper shot sequencer: blanks the screen for one frame, then flashes each live
// target in turn for a frame, reporting which one (if any) the photodiode saw.
module zapper_sequencer
  import zapper_pkg::*;
#(
  parameter int N_TARGETS = DEFAULT_N_TARGETS,
  parameter int SHOT_W    = 8
) (
  input  logic                         clk,
  input  logic                         screen_reset,
  input  logic                         frame_tick,
  input  logic                         active_video,
  input  logic                         trigger,
  input  logic                         light,
  input  logic [N_TARGETS-1:0]         target_active,
  output flash_mode_t                  flash_mode,
  output logic [$clog2(N_TARGETS)-1:0] target_idx,
  output logic                         hit_valid,
  output logic                         hit,
  output logic [$clog2(N_TARGETS)-1:0] hit_idx,
  output logic                         cheat,
  output logic [SHOT_W-1:0]            shot_count
);

  localparam int IDX_W = $clog2(N_TARGETS);

  // Returns {found, index} of the lowest set bit of mask at or above startIdx.
  function automatic logic [IDX_W:0] findSetBit(input logic [N_TARGETS-1:0] mask,
                                                input int startIdx);
    logic [IDX_W:0] result;
    result = '0;
    for (int i = N_TARGETS - 1; i >= 0; i--) begin
      if (mask[i] && (i >= startIdx)) result = {1'b1, IDX_W'(i)};
    end
    return result;
  endfunction

  state_t               r_state,     w_stateNext;
  logic [N_TARGETS-1:0] r_scanMask,  w_scanMaskNext;
  logic [IDX_W-1:0]     r_curIdx,    w_curIdxNext;
  logic [SHOT_W-1:0]    r_shotCount, w_shotCountNext;
  logic                 r_cheatFlag, w_cheatFlagNext;
  logic                 r_seen,      w_seenNext;
  logic                 r_hit,       w_hitNext;
  logic [IDX_W-1:0]     r_hitIdx,    w_hitIdxNext;
  logic                 r_cheat,     w_cheatNext;
  logic                 r_trigPrev;

  logic                 w_trigSync;
  logic                 w_lightSync;
  logic                 w_trigRise;
  logic                 w_sample;
  logic                 w_cheatNow;
  logic                 w_seenNow;
  logic [IDX_W:0]       w_lowest;
  logic [IDX_W:0]       w_next;

  sync2 u_trigSync (
    .clk          (clk),
    .screen_reset (screen_reset),
    .i_async      (trigger),
    .o_sync       (w_trigSync)
  );

  sync2 u_lightSync (
    .clk          (clk),
    .screen_reset (screen_reset),
    .i_async      (light),
    .o_sync       (w_lightSync)
  );

  assign w_trigRise = w_trigSync & ~r_trigPrev;
  assign w_sample   = w_lightSync & active_video;
  // A sample taken in the frame_tick cycle still counts toward the frame that is ending.
  assign w_cheatNow = r_cheatFlag | w_sample;
  assign w_seenNow  = r_seen | w_sample;
  assign w_lowest   = findSetBit(r_scanMask, 0);
  assign w_next     = findSetBit(r_scanMask, int'(r_curIdx) + 1);
  assign shot_count = r_shotCount;

  always_comb begin
    w_stateNext     = r_state;
    w_scanMaskNext  = r_scanMask;
    w_curIdxNext    = r_curIdx;
    w_shotCountNext = r_shotCount;
    w_cheatFlagNext = r_cheatFlag;
    w_seenNext      = r_seen;
    w_hitNext       = r_hit;
    w_hitIdxNext    = r_hitIdx;
    w_cheatNext     = r_cheat;
    flash_mode      = NORMAL;
    target_idx      = '0;
    hit_valid       = 1'b0;
    hit             = 1'b0;
    hit_idx         = '0;
    cheat           = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_cheatFlagNext = 1'b0;
        w_seenNext      = 1'b0;
        w_curIdxNext    = '0;
        if (w_trigRise) begin
          w_scanMaskNext  = target_active;
          w_shotCountNext = (r_shotCount == '1) ? r_shotCount : r_shotCount + SHOT_W'(1);
          w_stateNext     = frame_tick ? ST_BLACK : ST_PENDING;
        end
      end

      ST_PENDING: begin
        if (frame_tick) w_stateNext = ST_BLACK;
      end

      ST_BLACK: begin
        flash_mode = BLACK;
        if (w_sample) w_cheatFlagNext = 1'b1;
        if (frame_tick) begin
          w_cheatFlagNext = 1'b0;
          w_seenNext      = 1'b0;
          if (!w_lowest[IDX_W] || w_cheatNow) begin
            w_hitNext    = 1'b0;
            w_hitIdxNext = '0;
            w_cheatNext  = w_cheatNow;
            w_stateNext  = ST_RESULT;
          end else begin
            w_curIdxNext = w_lowest[IDX_W-1:0];
            w_stateNext  = ST_SCAN;
          end
        end
      end

      ST_SCAN: begin
        flash_mode = TARGET;
        target_idx = r_curIdx;
        if (w_sample) w_seenNext = 1'b1;
        if (frame_tick) begin
          w_seenNext = 1'b0;
          if (w_seenNow) begin
            w_hitNext    = 1'b1;
            w_hitIdxNext = r_curIdx;
            w_cheatNext  = 1'b0;
            w_stateNext  = ST_RESULT;
          end else if (w_next[IDX_W]) begin
            w_curIdxNext = w_next[IDX_W-1:0];
          end else begin
            w_hitNext    = 1'b0;
            w_hitIdxNext = '0;
            w_cheatNext  = 1'b0;
            w_stateNext  = ST_RESULT;
          end
        end
      end

      ST_RESULT: begin
        hit_valid   = 1'b1;
        hit         = r_hit;
        hit_idx     = r_hitIdx;
        cheat       = r_cheat;
        w_stateNext = ST_HELD;
      end

      ST_HELD: begin
        if (!w_trigSync) w_stateNext = ST_IDLE;
      end

      default: w_stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge screen_reset) begin
    if (screen_reset) begin
      r_state     <= ST_IDLE;
      r_scanMask  <= '0;
      r_curIdx    <= '0;
      r_shotCount <= '0;
      r_cheatFlag <= 1'b0;
      r_seen      <= 1'b0;
      r_hit       <= 1'b0;
      r_hitIdx    <= '0;
      r_cheat     <= 1'b0;
      r_trigPrev  <= 1'b0;
    end else begin
      r_state     <= w_stateNext;
      r_scanMask  <= w_scanMaskNext;
      r_curIdx    <= w_curIdxNext;
      r_shotCount <= w_shotCountNext;
      r_cheatFlag <= w_cheatFlagNext;
      r_seen      <= w_seenNext;
      r_hit       <= w_hitNext;
      r_hitIdx    <= w_hitIdxNext;
      r_cheat     <= w_cheatNext;
      r_trigPrev  <= w_trigSync;
    end
  end

endmodule

// File: tb/tb_zapper_sequencer.sv
// Frame-level bench for zapper_sequencer: a shot-queue reference model checked every
// cycle, plus literal expectations for each directed shot scenario.
module tb_zapper_sequencer;

  localparam int N_TARGETS = 4;
  localparam int SHOT_W    = 3;
  localparam int SHOT_MAX  = (1 << SHOT_W) - 1;
  localparam int FRAME_LEN = 12;
  localparam int ACTIVE_LEN = 8;

  localparam int PH_IDLE = 0, PH_PENDING = 1, PH_BLACK = 2, PH_SCAN = 3,
                 PH_RESULT = 4, PH_HELD = 5;

  logic                 clk;
  logic                 screen_reset;
  logic                 frame_tick;
  logic                 active_video;
  logic                 trigger;
  logic                 light;
  logic [N_TARGETS-1:0] target_active;
  zapper_pkg::flash_mode_t flash_mode;
  logic [1:0]           target_idx;
  logic                 hit_valid;
  logic                 hit;
  logic [1:0]           hit_idx;
  logic                 cheat;
  logic [SHOT_W-1:0]    shot_count;

  int passCount = 0;
  int totalCount = 0;

  int frameNo = 0;
  int hitPulses = 0;
  int capHit = -1, capIdx = -1, capCheat = -1, capFrame = -1;
  int visited[$];

  int  mPhase = PH_IDLE;
  int  scanQ[$];
  bit  lit;
  int  mCur;
  int  mResHit, mResIdx, mResCheat;
  int  mCount;
  bit  mTrigD1, mTrigS, mTrigPrev, mLightD1, mLightS;
  bit  sample, rise;

  zapper_sequencer #(
    .N_TARGETS (N_TARGETS),
    .SHOT_W    (SHOT_W)
  ) dut (
    .clk           (clk),
    .screen_reset  (screen_reset),
    .frame_tick    (frame_tick),
    .active_video  (active_video),
    .trigger       (trigger),
    .light         (light),
    .target_active (target_active),
    .flash_mode    (flash_mode),
    .target_idx    (target_idx),
    .hit_valid     (hit_valid),
    .hit           (hit),
    .hit_idx       (hit_idx),
    .cheat         (cheat),
    .shot_count    (shot_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: every check in the bench funnels through here.
  task automatic checkOutput(input string name, input int actual, input int expected);
    totalCount++;
    if (actual == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
  endtask

  // One frame of raster: trigger high from cycle trigFrom (-1 = low all frame),
  // light on during the visible part when lightOn, optional 2-cycle reset pulse.
  task automatic applyStimulus(input int trigFrom, input bit lightOn, input int resetAt);
    for (int c = 0; c < FRAME_LEN; c++) begin
      @(negedge clk);
      trigger      = (trigFrom >= 0) && (c >= trigFrom);
      active_video = (c < ACTIVE_LEN);
      light        = lightOn && (c < ACTIVE_LEN);
      frame_tick   = (c == FRAME_LEN - 1);
      screen_reset = (resetAt >= 0) && (c >= resetAt) && (c < resetAt + 2);
    end
    frameNo++;
  endtask

  task automatic startTest();
    hitPulses = 0;
    capHit = -1; capIdx = -1; capCheat = -1; capFrame = -1;
    visited.delete();
    frameNo = 0;
  endtask

  function automatic int visitedAt(input int k);
    if (k < visited.size()) return visited[k];
    return -1;
  endfunction

  // Reference model: a shot is a queue of live target indices consumed one per frame.
  always @(posedge clk) begin
    if (screen_reset) begin
      mPhase = PH_IDLE; scanQ.delete(); lit = 0; mCur = 0;
      mResHit = 0; mResIdx = 0; mResCheat = 0; mCount = 0;
      mTrigD1 = 0; mTrigS = 0; mTrigPrev = 0; mLightD1 = 0; mLightS = 0;
    end else begin
      sample = mLightS && active_video;
      rise   = mTrigS && !mTrigPrev;
      case (mPhase)
        PH_IDLE: if (rise) begin
          if (mCount < SHOT_MAX) mCount++;
          scanQ.delete();
          for (int i = 0; i < N_TARGETS; i++) if (target_active[i]) scanQ.push_back(i);
          lit = 0;
          mPhase = frame_tick ? PH_BLACK : PH_PENDING;
        end
        PH_PENDING: if (frame_tick) mPhase = PH_BLACK;
        PH_BLACK: begin
          lit = lit | sample;
          if (frame_tick) begin
            if (lit || scanQ.size() == 0) begin
              mResHit = 0; mResIdx = 0; mResCheat = lit; mPhase = PH_RESULT;
            end else begin
              mCur = scanQ.pop_front(); mPhase = PH_SCAN;
            end
            lit = 0;
          end
        end
        PH_SCAN: begin
          lit = lit | sample;
          if (frame_tick) begin
            if (lit) begin
              mResHit = 1; mResIdx = mCur; mResCheat = 0; mPhase = PH_RESULT;
            end else if (scanQ.size() == 0) begin
              mResHit = 0; mResIdx = 0; mResCheat = 0; mPhase = PH_RESULT;
            end else begin
              mCur = scanQ.pop_front();
            end
            lit = 0;
          end
        end
        PH_RESULT: mPhase = PH_HELD;
        PH_HELD: if (!mTrigS) mPhase = PH_IDLE;
        default: mPhase = PH_IDLE;
      endcase
      mTrigPrev = mTrigS; mTrigS = mTrigD1; mTrigD1 = trigger;
      mLightS = mLightD1; mLightD1 = light;
    end

    #1;
    checkOutput("flash_mode", int'(flash_mode),
                (mPhase == PH_BLACK) ? 1 : (mPhase == PH_SCAN) ? 2 : 0);
    checkOutput("target_idx", int'(target_idx), (mPhase == PH_SCAN) ? mCur : 0);
    checkOutput("hit_valid", int'(hit_valid), (mPhase == PH_RESULT) ? 1 : 0);
    checkOutput("hit", int'(hit), (mPhase == PH_RESULT) ? mResHit : 0);
    checkOutput("hit_idx", int'(hit_idx), (mPhase == PH_RESULT) ? mResIdx : 0);
    checkOutput("cheat", int'(cheat), (mPhase == PH_RESULT) ? mResCheat : 0);
    checkOutput("shot_count", int'(shot_count), mCount);

    if (hit_valid) begin
      hitPulses++;
      capHit = int'(hit); capIdx = int'(hit_idx); capCheat = int'(cheat); capFrame = frameNo;
    end
    if (flash_mode == zapper_pkg::TARGET &&
        (visited.size() == 0 || visited[visited.size()-1] != int'(target_idx)))
      visited.push_back(int'(target_idx));
  end

  initial begin
    screen_reset = 1'b1; frame_tick = 1'b0; active_video = 1'b0;
    trigger = 1'b0; light = 1'b0; target_active = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset flash_mode", int'(flash_mode), 0);
    checkOutput("reset shot_count", int'(shot_count), 0);
    checkOutput("reset hit_valid", int'(hit_valid), 0);
    checkOutput("reset target_idx", int'(target_idx), 0);
    screen_reset = 1'b0;
    applyStimulus(-1, 0, -1);
    applyStimulus(-1, 0, -1);

    $display("[TB] all targets live, light in frame of target 2");
    startTest();
    target_active = 4'b1111;
    applyStimulus(0, 0, -1);
    target_active = 4'b0001;
    applyStimulus(0, 0, -1);
    applyStimulus(0, 0, -1);
    applyStimulus(0, 0, -1);
    applyStimulus(0, 1, -1);
    applyStimulus(-1, 0, -1);
    applyStimulus(-1, 0, -1);
    checkOutput("t1 pulses", hitPulses, 1);
    checkOutput("t1 hit", capHit, 1);
    checkOutput("t1 hit_idx", capIdx, 2);
    checkOutput("t1 cheat", capCheat, 0);
    checkOutput("t1 frame", capFrame, 5);
    checkOutput("t1 visits", visited.size(), 3);
    checkOutput("t1 visit0", visitedAt(0), 0);
    checkOutput("t1 visit2", visitedAt(2), 2);
    checkOutput("t1 shots", int'(shot_count), 1);

    $display("[TB] sparse mask 1010, no light");
    startTest();
    target_active = 4'b1010;
    applyStimulus(0, 0, -1);
    applyStimulus(0, 0, -1);
    applyStimulus(0, 0, -1);
    applyStimulus(0, 0, -1);
    applyStimulus(-1, 0, -1);
    applyStimulus(-1, 0, -1);
    checkOutput("t2 pulses", hitPulses, 1);
    checkOutput("t2 hit", capHit, 0);
    checkOutput("t2 frame", capFrame, 4);
    checkOutput("t2 visits", visited.size(), 2);
    checkOutput("t2 visit0", visitedAt(0), 1);
    checkOutput("t2 visit1", visitedAt(1), 3);
    checkOutput("t2 shots", int'(shot_count), 2);

    $display("[TB] light during black frame");
    startTest();
    target_active = 4'b1111;
    applyStimulus(0, 0, -1);
    applyStimulus(0, 1, -1);
    applyStimulus(-1, 0, -1);
    applyStimulus(-1, 0, -1);
    checkOutput("t3 cheat", capCheat, 1);
    checkOutput("t3 hit", capHit, 0);
    checkOutput("t3 hit_idx", capIdx, 0);
    checkOutput("t3 frame", capFrame, 2);
    checkOutput("t3 visits", visited.size(), 0);
    checkOutput("t3 shots", int'(shot_count), 3);

    $display("[TB] trigger re-pressed mid-scan and held through result");
    startTest();
    target_active = 4'b1111;
    applyStimulus(0, 0, -1);
    applyStimulus(0, 0, -1);
    applyStimulus(-1, 0, -1);
    applyStimulus(0, 1, -1);
    applyStimulus(0, 0, -1);
    applyStimulus(0, 0, -1);
    checkOutput("t4 pulses", hitPulses, 1);
    checkOutput("t4 hit_idx", capIdx, 1);
    checkOutput("t4 frame", capFrame, 4);
    checkOutput("t4 shots held", int'(shot_count), 4);
    applyStimulus(-1, 0, -1);
    target_active = 4'b0000;
    applyStimulus(0, 0, -1);
    applyStimulus(0, 0, -1);
    applyStimulus(-1, 0, -1);
    checkOutput("t4 pulses after release", hitPulses, 2);
    checkOutput("t4 shots after release", int'(shot_count), 5);

    $display("[TB] trigger edge lands on frame_tick");
    startTest();
    target_active = 4'b0100;
    applyStimulus(9, 0, -1);
    applyStimulus(0, 0, -1);
    applyStimulus(0, 1, -1);
    applyStimulus(-1, 0, -1);
    checkOutput("t5 hit", capHit, 1);
    checkOutput("t5 hit_idx", capIdx, 2);
    checkOutput("t5 frame", capFrame, 3);
    checkOutput("t5 shots", int'(shot_count), 6);

    $display("[TB] reset during scan of target 1");
    startTest();
    target_active = 4'b1111;
    applyStimulus(0, 0, -1);
    applyStimulus(0, 0, -1);
    applyStimulus(-1, 0, -1);
    applyStimulus(-1, 0, 5);
    checkOutput("t6 shots after reset", int'(shot_count), 0);
    checkOutput("t6 flash after reset", int'(flash_mode), 0);
    applyStimulus(-1, 0, -1);
    applyStimulus(-1, 0, -1);
    checkOutput("t6 pulses", hitPulses, 0);

    $display("[TB] empty target mask");
    startTest();
    target_active = 4'b0000;
    applyStimulus(0, 0, -1);
    applyStimulus(0, 0, -1);
    applyStimulus(-1, 0, -1);
    checkOutput("t7 pulses", hitPulses, 1);
    checkOutput("t7 hit", capHit, 0);
    checkOutput("t7 cheat", capCheat, 0);
    checkOutput("t7 frame", capFrame, 2);
    checkOutput("t7 shots", int'(shot_count), 1);

    $display("[TB] shot counter saturation");
    for (int s = 0; s < 8; s++) begin
      applyStimulus(0, 0, -1);
      applyStimulus(0, 0, -1);
      applyStimulus(-1, 0, -1);
    end
    checkOutput("t8 saturated shots", int'(shot_count), SHOT_MAX);

    applyStimulus(-1, 0, -1);
    @(negedge clk);
    frame_tick = 1'b0;
    $display("[TB] %0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
